uart_rx_frame_checker: RTL and testbench

//  Receive-side counterpart of the TX parity/serializer path: consumes mid-bit samples of one

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rx_shift_parity.sv | 61 ++++++
 rtl/uart_rx_frame_checker.sv | 119 +++++++++++
 tb/tb_uart_rx_frame_checker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame checker: parity sense
// constants, the default word width and the frame FSM state encoding.
package uart_pkg;

  // Parity sense as seen on the PAR_TYP input.
  localparam logic EVEN_PARITY = 1'b1;
  localparam logic ODD_PARITY  = 1'b0;

  // Default number of data bits carried by one frame.
  localparam int DATA_WIDTH_DEFAULT = 8;

  // Frame reception phases: waiting for start, data bits, optional parity, stop.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Parity bit a transmitter would append to a word under the given sense.
  function automatic logic expectedParityBit(input logic runningXor, input logic parTyp);
    return (parTyp == EVEN_PARITY) ? runningXor : ~runningXor;
  endfunction

endpackage

// File: rtl/rx_shift_parity.sv
// Data-bit datapath of the frame checker: an LSB-first deserializer, a bit
// counter that flags the last data bit of the word, and a 1-bit running XOR
// of all data bits shifted in so far.
module rx_shift_parity
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic                  bit_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  parity_o,
  output logic                  last_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic                  parity_q, parity_d;

  // The counter sits on the last data bit when the current shift completes the word.
  assign last_o   = (bitCnt_q == LAST_CNT);
  assign data_o   = shift_q;
  assign parity_o = parity_q;

  // Next-state: clear at frame start, otherwise shift the new bit in at the MSB end
  // so the first received bit ends up as bit 0 once the word is complete.
  always_comb begin
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    parity_d = parity_q;
    if (clear_i) begin
      shift_d  = '0;
      bitCnt_d = '0;
      parity_d = 1'b0;
    end else if (shift_i) begin
      shift_d  = {bit_i, shift_q[DATA_WIDTH-1:1]};
      parity_d = parity_q ^ bit_i;
      bitCnt_d = last_o ? '0 : bitCnt_q + CNT_W'(1);
    end
  end

  // Datapath state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q  <= '0;
      bitCnt_q <= '0;
      parity_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      parity_q <= parity_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// UART receive frame checker: walks one frame of mid-bit samples through
// start, data, optional parity and stop, then either publishes the word with a
// one-cycle valid pulse or reports the parity/stop problem with error pulses.
module uart_rx_frame_checker
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  bit_tick,
  input  logic                  sampled_bit,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  busy
);

  rx_state_e             state_q;
  logic                  parEn_q;
  logic                  parTyp_q;
  logic                  parFlag_q;
  logic [DATA_WIDTH-1:0] pData_q;
  logic                  dataValid_q;
  logic                  parErr_q;
  logic                  stpErr_q;
  logic                  strtGlitch_q;

  logic                  startTick;
  logic                  dataTick;
  logic [DATA_WIDTH-1:0] shiftData;
  logic                  runParity;
  logic                  lastBit;
  logic                  parityBad;

  assign startTick = bit_tick && (state_q == IDLE) && !sampled_bit;
  assign dataTick  = bit_tick && (state_q == DATA);
  assign parityBad = sampled_bit != expectedParityBit(runParity, parTyp_q);

  rx_shift_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uShiftParity (
    .CLK     (CLK),
    .RST     (RST),
    .clear_i (startTick),
    .shift_i (dataTick),
    .bit_i   (sampled_bit),
    .data_o  (shiftData),
    .parity_o(runParity),
    .last_o  (lastBit)
  );

  // Frame FSM with registered result pulses; only ticked cycles move the frame along,
  // and the stop tick resolves the frame so the outcome appears on the next cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      parEn_q      <= 1'b0;
      parTyp_q     <= 1'b0;
      parFlag_q    <= 1'b0;
      pData_q      <= '0;
      dataValid_q  <= 1'b0;
      parErr_q     <= 1'b0;
      stpErr_q     <= 1'b0;
      strtGlitch_q <= 1'b0;
    end else begin
      dataValid_q  <= 1'b0;
      parErr_q     <= 1'b0;
      stpErr_q     <= 1'b0;
      strtGlitch_q <= 1'b0;
      if (bit_tick) begin
        case (state_q)
          IDLE: begin
            if (sampled_bit) begin
              strtGlitch_q <= 1'b1;
            end else begin
              state_q   <= DATA;
              parEn_q   <= PAR_EN;
              parTyp_q  <= PAR_TYP;
              parFlag_q <= 1'b0;
            end
          end
          DATA: begin
            if (lastBit) begin
              state_q <= parEn_q ? PARITY : STOP;
            end
          end
          PARITY: begin
            parFlag_q <= parityBad;
            state_q   <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!parFlag_q && sampled_bit) begin
              pData_q     <= shiftData;
              dataValid_q <= 1'b1;
            end else begin
              parErr_q <= parFlag_q;
              stpErr_q <= ~sampled_bit;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign P_DATA      = pData_q;
  assign data_valid  = dataValid_q;
  assign par_err     = parErr_q;
  assign stp_err     = stpErr_q;
  assign strt_glitch = strtGlitch_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Self-checking bench for uart_rx_frame_checker: directed frames followed by
// random frames, compared against a frame-level model of what the receiver owes.
module tb_uart_rx_frame_checker;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          bit_tick = 1'b0;
  logic          sampled_bit = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          strt_glitch;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] lastGood = '0;

  uart_rx_frame_checker #(
    .DATA_WIDTH(DW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bit_tick   (bit_tick),
    .sampled_bit(sampled_bit),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .strt_glitch(strt_glitch),
    .busy       (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  // One ticked sample; between ticks the line value is scrambled to prove it is ignored.
  task automatic tick(input logic b);
    bit_tick    = 1'b1;
    sampled_bit = b;
    step();
    bit_tick    = 1'b0;
    sampled_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_valid"}, 32'(data_valid), 32'd0);
    checkOutput({tag, "_parErr"}, 32'(par_err), 32'd0);
    checkOutput({tag, "_stpErr"}, 32'(stp_err), 32'd0);
    checkOutput({tag, "_glitch"}, 32'(strt_glitch), 32'd0);
  endtask

  task automatic applyReset(input string tag);
    RST = 1'b0;
    #1;
    checkQuiet(tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_pdata"}, 32'(P_DATA), 32'd0);
    lastGood = '0;
    step();
    RST = 1'b1;
  endtask

  // Sends one full frame starting with the start tick on the current cycle, then
  // checks the outcome against the frame-level rules.
  task automatic applyStimulus(input string tag, input logic [DW-1:0] data, input logic pe,
                               input logic pt, input logic pbit, input logic stopBit, input int maxGap);
    int   ones;
    logic expPar;
    logic expStp;
    logic expValid;
    PAR_EN  = pe;
    PAR_TYP = pt;
    tick(1'b0);
    PAR_EN  = 1'($urandom_range(0, 1));
    PAR_TYP = 1'($urandom_range(0, 1));
    checkOutput({tag, "_busyStart"}, 32'(busy), 32'd1);
    checkOutput({tag, "_validStart"}, 32'(data_valid), 32'd0);
    for (int i = 0; i < DW; i++) begin
      gap($urandom_range(0, maxGap));
      tick(data[i]);
    end
    if (pe) begin
      gap($urandom_range(0, maxGap));
      tick(pbit);
    end
    gap($urandom_range(0, maxGap));
    checkOutput({tag, "_busyPreStop"}, 32'(busy), 32'd1);
    tick(stopBit);
    ones     = $countones(data) + int'(pbit);
    expPar   = pe && (pt ? (ones % 2 != 0) : (ones % 2 != 1));
    expStp   = !stopBit;
    expValid = !expPar && !expStp;
    if (expValid) lastGood = data;
    checkOutput({tag, "_valid"}, 32'(data_valid), 32'(expValid));
    checkOutput({tag, "_parErr"}, 32'(par_err), 32'(expPar));
    checkOutput({tag, "_stpErr"}, 32'(stp_err), 32'(expStp));
    checkOutput({tag, "_pdata"}, 32'(P_DATA), 32'(lastGood));
    checkOutput({tag, "_busyEnd"}, 32'(busy), 32'd0);
  endtask

  // Directed scenarios, then randomized frames; every outcome comes from the frame model.
  initial begin
    $display("[TB] starting uart_rx_frame_checker bench");
    step();
    step();
    checkQuiet("por");
    checkOutput("por_busy", 32'(busy), 32'd0);
    checkOutput("por_pdata", 32'(P_DATA), 32'd0);
    RST = 1'b1;
    gap(2);

    gap(3);
    applyReset("rstIdle");
    gap(1);
    applyStimulus("preRst", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    gap(1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    checkOutput("midData_busy", 32'(busy), 32'd1);
    applyReset("rstData");
    gap(2);
    checkQuiet("postRst");
    applyStimulus("afterRst", 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1);

    gap(1);
    applyStimulus("evenA5", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    gap(2);
    applyStimulus("evenA5bad", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    gap(1);
    applyStimulus("odd07", 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    gap(1);
    applyStimulus("odd07bad", 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    gap(1);
    applyStimulus("noParStopBad", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    gap(1);
    applyStimulus("noParFF", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    gap(1);
    applyStimulus("bothErr", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1);

    gap(1);
    tick(1'b1);
    checkOutput("glitch_pulse", 32'(strt_glitch), 32'd1);
    checkOutput("glitch_busy", 32'(busy), 32'd0);
    step();
    checkOutput("glitch_clear", 32'(strt_glitch), 32'd0);

    applyStimulus("b2bFirst", 8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    applyStimulus("b2bSecond", 8'h42, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    applyStimulus("b2bThird", 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 2);

    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] d;
      logic          pe;
      logic          pt;
      logic          pb;
      logic          sb;
      d  = DW'($urandom);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      gap($urandom_range(0, 2));
      applyStimulus("rand", d, pe, pt, pb, sb, 2);
    end

    step();
    checkQuiet("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
